// File: rtl/melody_sequencer.sv
// melody_sequencer: plays one of four ROM melodies as timed one-hot note enables for the buzzer stage.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] melody_sel,
  input  logic       stop,
  output logic       note_do,
  output logic       note_re,
  output logic       note_mi,
  output logic       note_fa,
  output logic       note_sol,
  output logic       note_la,
  output logic       note_si,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_idx
);
  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_t;
  localparam logic [CNT_W-1:0] BEAT     = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  state_t           r_state, w_state;
  logic [1:0]       r_sel, w_sel;
  logic [3:0]       r_idx, w_idx;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [6:0]       r_notes, w_notes;
  logic             r_busy, r_done;
  logic [7:1]       w_rom;
  logic [2:0]       w_code;
  logic [3:0]       w_dur;
  logic [6:0]       w_onehot;
  logic [CNT_W-1:0] w_load;
  // ROM entry {code, dur}; the always-zero reserved bit 0 is not stored
  always_comb begin
    w_rom = '0;
    case ({r_sel, r_idx})
      6'd0:  w_rom = {3'd1, 4'd1};
      6'd1:  w_rom = {3'd3, 4'd1};
      6'd2:  w_rom = {3'd5, 4'd2};
      6'd16: w_rom = {3'd5, 4'd2};
      6'd17: w_rom = {3'd3, 4'd2};
      6'd18: w_rom = {3'd1, 4'd4};
      6'd32: w_rom = {3'd6, 4'd1};
      6'd33: w_rom = {3'd0, 4'd1};
      6'd34: w_rom = {3'd6, 4'd1};
      6'd35: w_rom = {3'd0, 4'd1};
      6'd48: w_rom = {3'd2, 4'd1};
      6'd49: w_rom = {3'd4, 4'd1};
      6'd50: w_rom = {3'd7, 4'd1};
      default: w_rom = '0;
    endcase
  end
  assign w_code   = w_rom[7:5];
  assign w_dur    = w_rom[4:1];
  assign w_onehot = (w_code == 3'd0) ? 7'd0 : 7'(7'd1 << (w_code - 3'd1));
  assign w_load   = {{(CNT_W-4){1'b0}}, w_dur} * BEAT - CNT_W'(1);
  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_notes = r_notes;
    if (stop) begin
      w_state = IDLE;
      w_idx   = '0;
      w_cnt   = '0;
      w_notes = '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          w_sel   = melody_sel;
          w_idx   = '0;
          w_state = FETCH;
        end
        FETCH: if (w_dur == 4'd0) w_state = DONE;
        else begin
          w_cnt   = w_load;
          w_notes = w_onehot;
          w_state = PLAY;
        end
        PLAY: if (r_cnt == '0) begin
          w_notes = '0;
          w_cnt   = GAP_LOAD;
          w_state = GAP;
        end else w_cnt = r_cnt - CNT_W'(1);
        GAP: if (r_cnt == '0) begin
          w_state = (r_idx == 4'd15) ? DONE : FETCH;
          w_idx   = (r_idx == 4'd15) ? r_idx : r_idx + 4'd1;
        end else w_cnt = r_cnt - CNT_W'(1);
        DONE:    w_state = IDLE;
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_notes <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_notes <= w_notes;
      r_busy  <= (w_state != IDLE);
      r_done  <= (w_state == DONE);
    end
  end
  assign {note_si, note_la, note_sol, note_fa, note_mi, note_re, note_do} = r_notes;
  assign busy     = r_busy;
  assign done     = r_done;
  assign note_idx = r_idx;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed bench; note traces are compressed into runs (value*1000+length).
module tb_melody_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0] melody_sel = 2'd0;
  logic note_do, note_re, note_mi, note_fa, note_sol, note_la, note_si, busy, done;
  logic [3:0] note_idx;
  logic [6:0] notes;
  int n_chk = 0, n_fail = 0;
  int runs[$], idxs[$], e_r[$], e_i[$];
  int dones, done_at, busy_n, multi, timeout;
  logic [31:0] acc;
  melody_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2), .CNT_W(28)) dut (
    .clk(clk), .rst(rst), .start(start), .melody_sel(melody_sel), .stop(stop),
    .note_do(note_do), .note_re(note_re), .note_mi(note_mi), .note_fa(note_fa),
    .note_sol(note_sol), .note_la(note_la), .note_si(note_si),
    .busy(busy), .done(done), .note_idx(note_idx)
  );
  assign notes = {note_si, note_la, note_sol, note_fa, note_mi, note_re, note_do};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic s, input logic [1:0] sel, input logic sp);
    @(posedge clk);
    #2;
    start = s;
    melody_sel = sel;
    stop = sp;
  endtask
  task automatic launch(input logic [1:0] sel);
    drive(1'b1, sel, 1'b0);
    drive(1'b0, sel, 1'b0);
  endtask
  task automatic record();
    runs = {}; idxs = {};
    dones = 0; done_at = -1; busy_n = 0; multi = 0; timeout = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) begin
        timeout = 0;
        break;
      end
      if ($countones(notes) > 1) multi++;
      if (done) begin
        dones++;
        done_at = busy_n;
      end
      if (idxs.size() == 0 || idxs[idxs.size()-1] != int'(note_idx)) idxs.push_back(int'(note_idx));
      if (busy_n > 0 && runs[runs.size()-1] / 1000 == int'(notes)) runs[runs.size()-1] += 1;
      else runs.push_back(int'(notes) * 1000 + 1);
      busy_n++;
    end
  endtask
  task automatic verify(input string tag);
    int total = 0;
    check($sformatf("%s timeout", tag), timeout, 0);
    check($sformatf("%s nruns", tag), runs.size(), e_r.size());
    foreach (e_r[i]) begin
      check($sformatf("%s run%0d", tag, i), (i < runs.size()) ? runs[i] : -1, e_r[i]);
      total += e_r[i] % 1000;
    end
    check($sformatf("%s nidx", tag), idxs.size(), e_i.size());
    foreach (e_i[i]) check($sformatf("%s idx%0d", tag, i), (i < idxs.size()) ? idxs[i] : -1, e_i[i]);
    check($sformatf("%s busy_cycles", tag), busy_n, total);
    check($sformatf("%s done_pulses", tag), dones, 1);
    check($sformatf("%s done_last", tag), done_at, busy_n - 1);
    check($sformatf("%s onehot", tag), multi, 0);
    check($sformatf("%s done_after", tag), done, 0);
    check($sformatf("%s notes_after", tag), notes, 0);
  endtask
  task automatic wait_bit(input string tag, input int b, input logic lvl);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (notes[b] === lvl) begin
        hit = 1'b1;
        break;
      end
    end
    check(tag, hit, 1);
  endtask
  initial begin
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst notes", notes, 0);
    check("rst idx", note_idx, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    acc = '0;
    repeat (50) begin
      @(negedge clk);
      acc |= {18'd0, busy, done, notes, note_idx};
    end
    check("idle_quiet", acc, 0);
    drive(1'b1, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b0);
    @(negedge clk);
    check("stop_wins busy", busy, 0);
    repeat (5) @(negedge clk);
    check("stop_wins idle", {busy, notes}, 0);
    launch(2'd0);
    record();
    e_r = '{1, 1010, 3, 4010, 3, 16020, 4};
    e_i = '{0, 1, 2, 3};
    verify("mel0");
    launch(2'd2);
    record();
    e_r = '{1, 32010, 16, 32010, 17};
    e_i = '{0, 1, 2, 3, 4};
    verify("mel2");
    launch(2'd1);
    fork
      record();
      begin
        repeat (25) @(posedge clk);
        #2;
        start = 1'b1;
        melody_sel = 2'd0;
        @(posedge clk);
        #2;
        start = 1'b0;
        melody_sel = 2'd3;
      end
    join
    e_r = '{1, 16020, 3, 4020, 3, 1040, 4};
    e_i = '{0, 1, 2, 3};
    verify("mel1");
    launch(2'd3);
    wait_bit("fa_reached", 3, 1'b1);
    repeat (3) @(negedge clk);
    check("fa_playing", note_fa, 1);
    drive(1'b0, 2'd3, 1'b1);
    drive(1'b0, 2'd3, 1'b0);
    @(negedge clk);
    check("abort notes", notes, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort idx", note_idx, 0);
    acc = '0;
    repeat (30) begin
      @(negedge clk);
      acc |= {30'd0, done, busy};
    end
    check("abort quiet", acc, 0);
    launch(2'd3);
    record();
    e_r = '{1, 2010, 3, 8010, 3, 64010, 4};
    e_i = '{0, 1, 2, 3};
    verify("mel3");
    launch(2'd0);
    wait_bit("mi_rise", 2, 1'b1);
    wait_bit("mi_fall", 2, 1'b0);
    check("gap busy", busy, 1);
    check("gap idx", note_idx, 1);
    #1 rst = 1'b1;
    #1;
    check("async busy", busy, 0);
    check("async idx", note_idx, 0);
    check("async notes", {done, notes}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc |= {21'd0, busy, done, notes, note_idx};
    end
    check("post_rst idle", acc, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
